// File: rtl/bram_dp_pkg.sv
// Shared types and helpers for the dual-port BRAM controller.
// Holds the state enum, the per-byte collision merge and the config check.
package bram_dp_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } bram_state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic bit cfg_ok(int dw, int lat);
    return (dw > 0) && (dw % 8 == 0) &&
           (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  // Returns {byte_enable, byte_data}; port A owns bytes both ports strobe.
  function automatic logic [8:0] strb_merge(
    logic       en_a,
    logic       en_b,
    logic [7:0] d_a,
    logic [7:0] d_b
  );
    return {en_a | en_b, en_a ? d_a : d_b};
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data latency pipe: turns an accepted read into dout/rvalid.
// Each stage only loads when its input is valid, so dout holds between reads.
module bram_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_i,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] dout_o,
  output logic          rvalid_o
);

  logic [LAT-1:0] v_q, v_d;
  logic [DW-1:0]  d_q [LAT];
  logic [DW-1:0]  d_d [LAT];

  always_comb begin
    v_d[0] = rd_i;
    d_d[0] = rd_i ? rdata_i : d_q[0];
    for (int i = 1; i < LAT; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < LAT; i++) d_q[i] <= d_d[i];
    end
  end

  assign dout_o   = d_q[LAT-1];
  assign rvalid_o = v_q[LAT-1];

endmodule

// File: rtl/bram_dp_ctrl.sv
// True dual-port byte-strobed BRAM with handshake, read pipe and clear engine.
// Reads are read-first; on a same-address write collision port A owns the byte.
module bram_dp_ctrl
  import bram_dp_pkg::*;
#(
  parameter int                   ADDR_WIDTH   = 10,
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic                    req_a,
  output logic                    ready_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] wstrb_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    rvalid_a,
  input  logic                    req_b,
  output logic                    ready_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] wstrb_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    rvalid_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  if (!cfg_ok(DATA_WIDTH, READ_LATENCY)) begin : g_bad_cfg
    $error("bram_dp_ctrl: bad DATA_WIDTH or READ_LATENCY");
  end

  bram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = RUN;
      end
      RUN: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  logic run, rd_a, rd_b, wr_a, wr_b;

  assign run      = (state_q == RUN);
  assign clr_busy = (state_q == CLEAR);
  assign ready_a  = run;
  assign ready_b  = run;
  assign rd_a     = req_a && run && !we_a;
  assign rd_b     = req_b && run && !we_b;
  assign wr_a     = req_a && run && we_a;
  assign wr_b     = req_b && run && we_b;

  logic [NB-1:0]         en_a, en_b;
  logic [DATA_WIDTH-1:0] wd_a, wd_b;
  logic [ADDR_WIDTH-1:0] wa_a;

  always_comb begin
    en_a = wr_a ? wstrb_a : '0;
    en_b = wr_b ? wstrb_b : '0;
    wd_a = din_a;
    wd_b = din_b;
    wa_a = addr_a;
    if (clr_busy) begin
      en_a = '1;
      wd_a = INIT_WORD;
      wa_a = ptr_q;
    end else if (wr_a && wr_b && addr_a == addr_b) begin
      // Fold both writers into lane A so each byte sees one write.
      for (int i = 0; i < NB; i++) begin
        {en_a[i], wd_a[i*8 +: 8]} = strb_merge(
          wstrb_a[i], wstrb_b[i], din_a[i*8 +: 8], din_b[i*8 +: 8]);
      end
      en_b = '0;
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (en_b[i]) mem_q[addr_b][i*8 +: 8] <= wd_b[i*8 +: 8];
      if (en_a[i]) mem_q[wa_a][i*8 +: 8]   <= wd_a[i*8 +: 8];
    end
  end

  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  assign rdata_a = mem_q[addr_a];
  assign rdata_b = mem_q[addr_b];

  bram_rd_pipe #(
    .DW  (DATA_WIDTH),
    .LAT (READ_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_i     (rd_a),
    .rdata_i  (rdata_a),
    .dout_o   (dout_a),
    .rvalid_o (rvalid_a)
  );

  bram_rd_pipe #(
    .DW  (DATA_WIDTH),
    .LAT (READ_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_i     (rd_b),
    .rdata_i  (rdata_b),
    .dout_o   (dout_b),
    .rvalid_o (rvalid_b)
  );

endmodule

// File: doc/bram_dp_ctrl.md
Name: bram_dp_ctrl

Overview:
Parametrised true dual-port byte-strobed block RAM, successor to the plain two-port BRAM. Adds per-port request/ready handshake, read-data valid strobes, selectable read latency (1 or 2), deterministic same-cycle collision rules, and a hardware clear engine that fills the array with INIT_WORD after reset or on request. It is the memory primitive for the core's instruction/data stores and for debug-loader access.

Parameters:
ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8, otherwise elaboration error
READ_LATENCY, 1, cycles from accepted read to rvalid; legal values 1 or 2, otherwise elaboration error
INIT_WORD, 0, value written to every word by the clear engine

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  pulse; starts a clear pass when the block is not already clearing
clr_busy  out  1  high while the clear engine runs
req_a  in  1  port A request
ready_a  out  1  port A can accept; transfer when req_a && ready_a
we_a  in  1  1 = write, 0 = read
wstrb_a  in  DATA_WIDTH/8  byte enables for write
addr_a  in  ADDR_WIDTH  word address
din_a  in  DATA_WIDTH  write data
dout_a  out  DATA_WIDTH  read data
rvalid_a  out  1  one-cycle pulse; dout_a valid
req_b, ready_b, we_b, wstrb_b, addr_b, din_b, dout_b, rvalid_b  port B, identical to port A

Behaviour:
- Reset (rst_n low, asynchronous): state = CLEAR, clear pointer = 0, clr_busy = 1, ready_a/b = 0, rvalid_a/b = 0, dout_a/b = 0, all latency-pipe stages invalid. Array contents are not reset directly; the clear pass overwrites them.
- States: CLEAR and RUN.
- CLEAR: writes INIT_WORD to address ptr each cycle, with ptr running 0..DEPTH-1. After the write to DEPTH-1, the next state is RUN. This takes exactly DEPTH cycles after rst_n rises. ready_a/b = 0 and clr_busy = 1 throughout.
- RUN: ready_a = ready_b = 1. A clr_req sampled high moves the block to CLEAR with ptr = 0. ready drops on the following cycle.
- clr_req while in CLEAR is ignored; the pass is not restarted.
- Reads issued before clr_req still complete: pipeline data and rvalid drain normally.
- Accepted write: byte i of mem[addr] is updated iff wstrb[i] = 1. A write with wstrb = 0 is a legal no-op and produces no rvalid.
- Accepted read: returns the array contents before any write in the same cycle (read-first, on both ports).
  - READ_LATENCY = 1: dout/rvalid update on the edge after acceptance.
  - READ_LATENCY = 2: an extra output register delays them by one more edge.
  - Fully pipelined: one read per port per cycle.
- dout holds its last value when rvalid = 0. Writes never produce rvalid.
- Collision, both ports writing the same address in the same cycle: per byte, port A wins where both strobes are set. Bytes strobed only by B take din_b.
- Collision, one port reads an address the other port writes in the same cycle: the reader gets old data.
- Address wrap: none; the address is exactly ADDR_WIDTH bits, so every value is in range.
- Reset asserted mid-clear or mid-read: everything returns to the reset state and the clear pass restarts from 0. In-flight rvalids are discarded.

Decomposition:
- Package bram_dp_pkg holds:
  - state enum bram_state_e {CLEAR, RUN};
  - function strb_merge(), which merges per-byte A/B write data and enables;
  - localparam checks for the DATA_WIDTH % 8 and READ_LATENCY rules.
- Sub-module bram_rd_pipe is instantiated once per port. It takes raw array data plus a read-accepted flag and delivers dout/rvalid with READ_LATENCY stages, reset to zero/invalid.
- The array is a single clocked write/read process. It merges port A, port B and the clear engine, giving one write per byte per address.

Test Plan:
- Release reset with DEPTH = 1024 and INIT_WORD = 0xDEADBEEF -> clr_busy high for exactly 1024 cycles, ready_a/b low throughout; then read addr 0 and 1023 -> 0xDEADBEEF, each with one rvalid pulse.
- Port A writes addr 5 = 0x11223344 with wstrb = 0101, then port B reads addr 5 -> 0xDE22BE44 (over initial 0xDEADBEEF). rvalid_b arrives 1 cycle after acceptance with READ_LATENCY = 1 and 2 cycles with READ_LATENCY = 2.
- Same cycle: A writes addr 9 = 0xAAAAAAAA with wstrb 0011, B writes addr 9 = 0xBBBBBBBB with wstrb 0110 -> readback 0xDEBBAAAA (byte1 taken from A).
- Same cycle: A writes addr 3 = 0x0 while B reads addr 3 -> dout_b = old value 0xDEADBEEF; a later read -> 0x00000000.
- Back-to-back reads on both ports, addr 0..15, every cycle, READ_LATENCY = 2 -> 16 consecutive rvalid pulses per port with data in order and no bubbles.
- Pulse clr_req in RUN, then assert rst_n low at cycle 100 of the pass -> clr_busy stays high. A new full DEPTH-cycle pass starts from address 0 after release, and no rvalid appears during the pass.
